lpm_deshiftreg_16_right: RTL and testbench

Serial-in/parallel-out receiver that reassembles 16-bit words from the serial `ShiftOut` stream of the team's right-shifting `LPM_SHIFTREG` transmitter. That transmitter emits bit 0 first. The block sits at the far end of the serial link. It frames words with a `Start` qualifier, counts bits, and presents each completed word in a holding register with a Valid/Ack handshake and a sticky overrun flag.

---
 rtl/lpm_deshiftreg_16_right.sv | 95 +++++++++
 tb/tb_lpm_deshiftreg_16_right.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lpm_deshiftreg_16_right.sv
// Serial-in/parallel-out receiver: frames words with Start, counts bits and
// presents each completed word in a holding register with Valid/Ack and sticky Overrun.
module lpm_deshiftreg_16_right #(
   parameter int    lpm_width     = 16,
   parameter string lpm_direction = "RIGHT"
) (
   input  logic                 Clock,
   input  logic                 Sclr,
   input  logic                 Enable,
   input  logic                 ShiftIn,
   input  logic                 Start,
   input  logic                 Ack,
   output logic [lpm_width-1:0] Q,
   output logic                 Valid,
   output logic                 Busy,
   output logic                 Overrun
);

   localparam int CNT_W = (lpm_width > 2) ? $clog2(lpm_width) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(lpm_width - 1);
   localparam bit IS_LEFT = (lpm_direction == "LEFT");

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_q, state_d;
   logic [lpm_width-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [lpm_width-1:0] q_q, q_d;
   logic                 valid_q, valid_d;
   logic                 overrun_q, overrun_d;
   logic [lpm_width-1:0] shifted;

   always_comb begin
      if (IS_LEFT) shifted = {sr_q[lpm_width-2:0], ShiftIn};
      else         shifted = {ShiftIn, sr_q[lpm_width-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      q_d       = q_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      // The Ack clear comes first so a completion on the same edge can re-set Valid.
      if (valid_q && Ack) valid_d = 1'b0;

      if (Enable) begin
         if (Start) begin
            sr_d    = shifted;
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
         end else if (state_q == SHIFT) begin
            sr_d = shifted;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!valid_q || Ack) begin
                  q_d     = shifted;
                  valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Sclr) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         q_q       <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign Q       = q_q;
   assign Valid   = valid_q;
   assign Busy    = (state_q == SHIFT);
   assign Overrun = overrun_q;

endmodule

// File: tb/tb_lpm_deshiftreg_16_right.sv
// Bench for lpm_deshiftreg_16_right: a RIGHT and a LEFT instance share one serial
// stream and are compared every cycle against a bit-list model of the link.
module tb_lpm_deshiftreg_16_right;

   logic clock = 1'b0;
   logic sclr = 1'b0, enable = 1'b0, shiftIn = 1'b0, start = 1'b0, ack = 1'b0;
   logic [15:0] qR, qL;
   logic validR, busyR, overrunR, validL, busyL, overrunL;

   int nChecks = 0;
   int nPass = 0;

   // Model state: index 0 is the RIGHT instance, index 1 the LEFT instance
   bit          bits[$];
   bit          inFrame = 1'b0;
   bit          modelReady = 1'b0;
   bit          mBusy = 1'b0;
   logic [15:0] mQ[2];
   bit          mValid[2];
   bit          mOverrun[2];

   always #5 clock = ~clock;

   lpm_deshiftreg_16_right #(.lpm_width(16), .lpm_direction("RIGHT")) dutR (
      .Clock(clock), .Sclr(sclr), .Enable(enable), .ShiftIn(shiftIn), .Start(start), .Ack(ack),
      .Q(qR), .Valid(validR), .Busy(busyR), .Overrun(overrunR)
   );

   lpm_deshiftreg_16_right #(.lpm_width(16), .lpm_direction("LEFT")) dutL (
      .Clock(clock), .Sclr(sclr), .Enable(enable), .ShiftIn(shiftIn), .Start(start), .Ack(ack),
      .Q(qL), .Valid(validL), .Busy(busyL), .Overrun(overrunL)
   );

   // Advance the model by one edge from the inputs the edge samples
   task automatic modelStep();
      logic [15:0] word[2];
      bit done;
      done = 1'b0;
      word[0] = '0;
      word[1] = '0;
      if (sclr) begin
         bits.delete();
         inFrame = 1'b0;
         mBusy = 1'b0;
         for (int k = 0; k < 2; k++) begin
            mQ[k] = '0;
            mValid[k] = 1'b0;
            mOverrun[k] = 1'b0;
         end
         modelReady = 1'b1;
         return;
      end
      if (enable) begin
         if (start) begin
            bits.delete();
            bits.push_back(shiftIn);
            inFrame = 1'b1;
         end else if (inFrame) begin
            bits.push_back(shiftIn);
            if (bits.size() == 16) begin
               for (int i = 0; i < 16; i++) begin
                  word[0][i] = bits[i];
                  word[1][15-i] = bits[i];
               end
               done = 1'b1;
               inFrame = 1'b0;
               bits.delete();
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (done) begin
            if (!mValid[k] || ack) begin
               mQ[k] = word[k];
               mValid[k] = 1'b1;
            end else begin
               mOverrun[k] = 1'b1;
            end
         end else if (mValid[k] && ack) begin
            mValid[k] = 1'b0;
         end
      end
      mBusy = inFrame;
   endtask

   // Per-cycle comparison of both instances against the model
   always @(posedge clock) begin
      modelStep();
      #1;
      if (modelReady) begin
         nChecks++;
         if ({qR, validR, busyR, overrunR} === {mQ[0], mValid[0], mBusy, mOverrun[0]}) nPass++;
         else $display("[TB] FAIL model_right @%0t: got Q=%h V=%b B=%b O=%b, expected Q=%h V=%b B=%b O=%b",
                       $time, qR, validR, busyR, overrunR, mQ[0], mValid[0], mBusy, mOverrun[0]);
         nChecks++;
         if ({qL, validL, busyL, overrunL} === {mQ[1], mValid[1], mBusy, mOverrun[1]}) nPass++;
         else $display("[TB] FAIL model_left @%0t: got Q=%h V=%b B=%b O=%b, expected Q=%h V=%b B=%b O=%b",
                       $time, qL, validL, busyL, overrunL, mQ[1], mValid[1], mBusy, mOverrun[1]);
      end
   end

   task automatic applyStimulus(input logic s, input logic en, input logic sin, input logic st, input logic a);
      sclr = s;
      enable = en;
      shiftIn = sin;
      start = st;
      ack = a;
      @(negedge clock);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic sendWord(input logic [15:0] w, input bit msbFirst, input int gap, input bit ackLast);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, msbFirst ? w[15-i] : w[i], (i == 0), ackLast && (i == 15));
         if (i != 15)
            for (int g = 0; g < gap; g++)
               applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   initial begin
      // Reset with random activity on the other inputs
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("reset_q", qR, 16'h0000);
      checkOutput("reset_flags", {13'b0, validR, busyR, overrunR}, 16'h0000);

      // Enabled bits without Start are discarded
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("idle_busy", {15'b0, busyR}, 16'h0000);

      // Basic RIGHT frame and Ack
      sendWord(16'hA5C3, 1'b0, 0, 1'b0);
      checkOutput("basic_q", qR, 16'hA5C3);
      checkOutput("basic_valid_busy", {14'b0, validR, busyR}, 16'h0002);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ack_valid", {15'b0, validR}, 16'h0000);
      checkOutput("ack_q_held", qR, 16'hA5C3);

      // Gapped strobe
      sendWord(16'h1234, 1'b0, 2, 1'b0);
      checkOutput("gapped_q", qR, 16'h1234);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Resync: partial frame of ones, then a fresh Start
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      sendWord(16'h00F0, 1'b0, 0, 1'b0);
      checkOutput("resync_q", qR, 16'h00F0);
      checkOutput("resync_overrun", {15'b0, overrunR}, 16'h0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun: second word dropped without Ack, flag sticky
      sendWord(16'h0001, 1'b0, 0, 1'b0);
      sendWord(16'h8000, 1'b0, 0, 1'b0);
      checkOutput("overrun_q", qR, 16'h0001);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("overrun_sticky", {15'b0, overrunR}, 16'h0001);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      sendWord(16'h0001, 1'b0, 0, 1'b0);
      sendWord(16'h8000, 1'b0, 0, 1'b1);
      checkOutput("ack_replace_q", qR, 16'h8000);
      checkOutput("ack_replace_flags", {14'b0, validR, overrunR}, 16'h0002);

      // Sclr mid-frame, stray bits, then a full frame
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("sclr_mid_q", qR, 16'h0000);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("sclr_no_start_busy", {15'b0, busyR}, 16'h0000);
      sendWord(16'h5555, 1'b0, 0, 1'b0);
      checkOutput("after_sclr_q", qR, 16'h5555);
      checkOutput("after_sclr_valid", {15'b0, validR}, 16'h0001);

      // MSB-first stream: LEFT instance rebuilds the word, RIGHT sees it bit-reversed
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      sendWord(16'hA5C3, 1'b1, 0, 1'b0);
      checkOutput("left_q", qL, 16'hA5C3);
      checkOutput("left_right_rev_q", qR, 16'hC3A5);

      // Randomized traffic
      for (int i = 0; i < 3000; i++)
         applyStimulus(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 3) == 0));

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
